// File: rtl/resize_pkg.sv
// Shared definitions for the resize_round_sat width converter.
//   ROUND_*  : encodings of the round_mode input
//   q_width  : width of the rounded intermediate (LENGTH_IN - DROP + 1),
//              one bit wider than the shifted sample so a rounding carry
//              is never lost before saturation.
package resize_pkg;

  localparam logic [1:0] ROUND_TRUNC      = 2'd0;
  localparam logic [1:0] ROUND_HALF_UP    = 2'd1;
  localparam logic [1:0] ROUND_CONVERGENT = 2'd2;
  localparam logic [1:0] ROUND_HALF_AWAY  = 2'd3;

  function automatic int q_width(input int length_in, input int drop);
    return length_in - drop + 1;
  endfunction

endpackage

// File: rtl/resize_round_sat_round_stage.sv
// round_stage: combinational rounding of a signed sample by 2^DROP.
//   data : signed input sample, LENGTH_IN bits
//   mode : rounding mode (ROUND_* from resize_pkg)
//   q    : rounded quotient, LENGTH_IN-DROP+1 bits (carry bit kept)
// With DROP = 0 the sample passes through unchanged (sign-extended by one).
module round_stage
  import resize_pkg::*;
#(
  parameter int LENGTH_IN = 16,
  parameter int DROP      = 4
) (
  input  logic [LENGTH_IN-1:0]    data,
  input  logic [1:0]              mode,
  output logic [LENGTH_IN-DROP:0] q
);

  localparam int QW = q_width(LENGTH_IN, DROP);

  if (DROP == 0) begin : g_identity
    logic unused_mode;
    assign unused_mode = ^mode;
    assign q = {data[LENGTH_IN-1], data};
  end else begin : g_round
    localparam int BW = LENGTH_IN - DROP;
    localparam logic [DROP-1:0] HALF = DROP'(1) << (DROP - 1);

    logic [BW-1:0]   base;  // floor(data / 2^DROP): upper bits of a two's complement word
    logic [DROP-1:0] rem;   // discarded fraction, always non-negative
    logic            inc;

    assign base = data[LENGTH_IN-1:DROP];
    assign rem  = data[DROP-1:0];

    always_comb begin
      // NOTE: give every combinational output a default first so no path
      // through the case leaves it unassigned and infers a latch.
      inc = 1'b0;
      case (mode)
        ROUND_TRUNC:      inc = 1'b0;
        ROUND_HALF_UP:    inc = (rem >= HALF);
        // Ties go to the even neighbour: bump only when floor is odd.
        ROUND_CONVERGENT: inc = (rem > HALF) || ((rem == HALF) && base[0]);
        // Ties go away from zero: up for positives, stay at floor for negatives.
        ROUND_HALF_AWAY:  inc = (rem > HALF) || ((rem == HALF) && !data[LENGTH_IN-1]);
        default:          inc = 1'b0;
      endcase
    end

    assign q = {base[BW-1], base} + QW'(inc);
  end

endmodule

// File: rtl/resize_round_sat.sv
// resize_round_sat: two-stage pipelined signed width converter.
//   S1 registers the rounded value (round_stage), S2 registers the
//   saturated / sign-extended result. Valid/ready on both sides, full
//   throughput with out_ready held high, latency 2 cycles.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : input handshake; in_data + round_mode sampled on transfer
//   out_valid/out_ready    : output handshake; out_data/out_sat held while stalled
//   out_sat                : the presented sample was clamped
//   ovf_sticky, ovf_clr    : sticky flag set by a transferred clamped sample
//   ovf_count (optional)   : 16-bit saturating count of transferred clamped
//                            samples, present when RESIZE_OVF_COUNT_EN is defined
module resize_round_sat
  import resize_pkg::*;
#(
  parameter int LENGTH_IN  = 16,
  parameter int LENGTH_OUT = 12,
  parameter int DROP       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LENGTH_IN-1:0]  in_data,
  input  logic [1:0]            round_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LENGTH_OUT-1:0] out_data,
  output logic                  out_sat,
  output logic                  ovf_sticky,
`ifdef RESIZE_OVF_COUNT_EN
  output logic [15:0]           ovf_count,
`endif
  input  logic                  ovf_clr
);

  localparam int QW = q_width(LENGTH_IN, DROP);

  logic [QW-1:0]         q_next;
  logic                  s1_valid;
  logic [QW-1:0]         s1_q;
  logic                  s1_adv;
  logic                  s2_adv;
  logic [LENGTH_OUT-1:0] sat_data;
  logic                  sat_flag;
  logic                  xfer_sat;

  round_stage #(.LENGTH_IN(LENGTH_IN), .DROP(DROP)) u_round (
    .data (in_data),
    .mode (round_mode),
    .q    (q_next)
  );

  // A stage may load when its own slot is empty or is being drained.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = !rst && s1_adv;
  assign xfer_sat = out_valid && out_ready && out_sat;

  if (QW > LENGTH_OUT) begin : g_clamp
    logic [QW-LENGTH_OUT:0] upper;
    logic                   fits;
    // q fits when every bit above the output sign bit copies it.
    assign upper = s1_q[QW-1:LENGTH_OUT-1];
    assign fits  = (&upper) || !(|upper);
    always_comb begin
      sat_flag = !fits;
      sat_data = s1_q[LENGTH_OUT-1:0];
      if (!fits)
        sat_data = s1_q[QW-1] ? {1'b1, {(LENGTH_OUT-1){1'b0}}}
                              : {1'b0, {(LENGTH_OUT-1){1'b1}}};
    end
  end else begin : g_extend
    assign sat_flag = 1'b0;
    assign sat_data = LENGTH_OUT'($signed(s1_q));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= sat_data;
          out_sat  <= sat_flag;
        end
      end
      if (xfer_sat)     ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  end

  // NOTE: the S1 data register carries no reset; s1_valid qualifies it, so
  // its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) s1_q <= q_next;
  end

`ifdef RESIZE_OVF_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                  ovf_count <= '0;
    else if (ovf_clr)                         ovf_count <= {15'd0, xfer_sat};
    else if (xfer_sat && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
  end
`endif

endmodule
